// File: rtl/eth_mdio_pkg.sv
// eth_mdio_pkg: CSR word map, PHY register bit positions and init sequencer states
package eth_mdio_pkg;
    localparam logic [5:0] ADDR_REG  = 6'h21;
    localparam logic [5:0] REG_BMCR  = 6'h00;
    localparam logic [5:0] REG_BMSR  = 6'h01;
    localparam logic [5:0] REG_PHYSR = 6'h11;
    localparam int BMCR_RST     = 15;
    localparam int BMSR_LINK    = 2;
    localparam int PHYSR_SPD_HI = 15;
    typedef enum logic [2:0] {
        WAIT_START,
        SET_ADDR,
        WR_BMCR,
        RST_GAP,
        RD_BMCR,
        RD_BMSR,
        RD_PHYSR,
        POLL_WAIT
    } init_state_t;
    function automatic logic is_access(input init_state_t s);
        return s inside {SET_ADDR, WR_BMCR, RD_BMCR, RD_BMSR, RD_PHYSR};
    endfunction
    function automatic logic [5:0] access_addr(input init_state_t s);
        return s == SET_ADDR ? ADDR_REG : s == RD_BMSR ? REG_BMSR : s == RD_PHYSR ? REG_PHYSR : REG_BMCR;
    endfunction
endpackage

// File: rtl/mdio_csr_access.sv
// mdio_csr_access: one Avalon-MM CSR access per start pulse, holds the bus until waitrequest drops
//   start/is_read/addr/wdata : access request, sampled only while the bus is idle
//   done/rdata               : one-cycle completion pulse, read data [15:0] captured at completion
//   csr_*                    : Avalon-MM initiator port towards eth_mdio
module mdio_csr_access (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_read,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [15:0] rdata,
    output logic        csr_write,
    output logic        csr_read,
    output logic [5:0]  csr_address,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata,
    input  logic        csr_waitrequest
);
    logic active;
    logic unused_rdata_hi;
    assign active = csr_read | csr_write;
    assign unused_rdata_hi = ^csr_readdata[31:16];
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            csr_write     <= 1'b0;
            csr_read      <= 1'b0;
            csr_address   <= '0;
            csr_writedata <= '0;
            done          <= 1'b0;
            rdata         <= '0;
        end else begin
            done <= 1'b0;
            if (active && !csr_waitrequest) begin
                csr_write <= 1'b0;
                csr_read  <= 1'b0;
                done      <= 1'b1;
                if (csr_read) rdata <= csr_readdata[15:0];
            end else if (start && !active) begin
                csr_write     <= !is_read;
                csr_read      <= is_read;
                csr_address   <= addr;
                csr_writedata <= is_read ? '0 : wdata;
            end
        end
    end
endmodule

// File: rtl/phy_mdio_init.sv
// phy_mdio_init: brings the RGMII PHY out of reset via eth_mdio CSRs, then polls link and speed forever
//   clk_50, rst_n          : clock, asynchronous active-low reset
//   csr_*                  : Avalon-MM initiator port to eth_mdio
//   init_done / cfg_error  : BMCR reset self-cleared / never cleared (sticky, exclusive)
//   link_up / link_speed   : BMSR link bit and PHYSR speed field from the last poll round
module phy_mdio_init
    import eth_mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR      = 5'd0,
    parameter logic [23:0] START_DELAY   = 24'd50000,
    parameter logic [15:0] BMCR_INIT     = 16'h9140,
    parameter logic [15:0] RST_POLL_GAP  = 16'd1000,
    parameter logic [7:0]  RST_POLL_MAX  = 8'd100,
    parameter logic [23:0] POLL_INTERVAL = 24'd5000000
) (
    input  logic        clk_50,
    input  logic        rst_n,
    output logic        csr_write,
    output logic        csr_read,
    output logic [5:0]  csr_address,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata,
    input  logic        csr_waitrequest,
    output logic        init_done,
    output logic        cfg_error,
    output logic        link_up,
    output logic [1:0]  link_speed
);
    init_state_t state, state_n;
    logic [23:0] cnt;
    logic [7:0]  poll_cnt;
    logic [7:0]  poll_max;
    logic        poll_last;
    logic        start;
    logic        is_read;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic [15:0] rdata;
    assign poll_max  = RST_POLL_MAX == 8'd0 ? 8'd1 : RST_POLL_MAX;
    assign poll_last = (poll_cnt + 8'd1) == poll_max;
    mdio_csr_access u_access (
        .clk_50          (clk_50),
        .rst_n           (rst_n),
        .start           (start),
        .is_read         (is_read),
        .addr            (addr),
        .wdata           (wdata),
        .done            (done),
        .rdata           (rdata),
        .csr_write       (csr_write),
        .csr_read        (csr_read),
        .csr_address     (csr_address),
        .csr_writedata   (csr_writedata),
        .csr_readdata    (csr_readdata),
        .csr_waitrequest (csr_waitrequest)
    );
    // Accesses are launched on entry to an access state, so a zero-length wait issues immediately
    always_comb begin
        state_n = state;
        case (state)
            WAIT_START: state_n = cnt == START_DELAY ? SET_ADDR : WAIT_START;
            SET_ADDR:   state_n = done ? WR_BMCR : SET_ADDR;
            WR_BMCR:    state_n = done ? RST_GAP : WR_BMCR;
            RST_GAP:    state_n = cnt == {8'b0, RST_POLL_GAP} ? RD_BMCR : RST_GAP;
            RD_BMCR:    state_n = !done ? RD_BMCR : (!rdata[BMCR_RST] || poll_last) ? RD_BMSR : RST_GAP;
            RD_BMSR:    state_n = done ? RD_PHYSR : RD_BMSR;
            RD_PHYSR:   state_n = done ? POLL_WAIT : RD_PHYSR;
            POLL_WAIT:  state_n = cnt == POLL_INTERVAL ? RD_BMSR : POLL_WAIT;
            default:    state_n = WAIT_START;
        endcase
        start   = is_access(state_n) && state_n != state;
        is_read = !(state_n == SET_ADDR || state_n == WR_BMCR);
        addr    = access_addr(state_n);
        wdata   = state_n == SET_ADDR ? {11'b0, PHY_ADDR, 16'b0} : {16'b0, BMCR_INIT};
    end
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_START;
            cnt        <= '0;
            poll_cnt   <= '0;
            init_done  <= 1'b0;
            cfg_error  <= 1'b0;
            link_up    <= 1'b0;
            link_speed <= 2'b00;
        end else begin
            state <= state_n;
            cnt   <= state_n != state ? '0 : cnt + 24'd1;
            if (state == RD_BMCR && done) begin
                poll_cnt  <= poll_cnt + 8'd1;
                init_done <= init_done | !rdata[BMCR_RST];
                cfg_error <= cfg_error | (rdata[BMCR_RST] & poll_last);
            end
            if (state == RD_BMSR && done) link_up <= rdata[BMSR_LINK];
            if (state == RD_PHYSR && done) link_speed <= rdata[PHYSR_SPD_HI -: 2];
        end
    end
endmodule

// File: tb/tb_phy_mdio_init.sv
// tb_phy_mdio_init: scoreboard-driven Avalon target for phy_mdio_init
module tb_phy_mdio_init;
    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        csr_write;
    logic        csr_read;
    logic [5:0]  csr_address;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata = '0;
    logic        csr_waitrequest = 1'b1;
    logic        init_done;
    logic        cfg_error;
    logic        link_up;
    logic [1:0]  link_speed;
    int total = 0;
    int bad = 0;
    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [15:0] rd;
        int          ws;
        int          lat;
    } acc_t;
    acc_t sb[$];
    always #10 clk_50 = ~clk_50;
    phy_mdio_init #(
        .PHY_ADDR      (5'h13),
        .START_DELAY   (24'd10),
        .BMCR_INIT     (16'h9140),
        .RST_POLL_GAP  (16'd3),
        .RST_POLL_MAX  (8'd4),
        .POLL_INTERVAL (24'd20)
    ) dut (
        .clk_50          (clk_50),
        .rst_n           (rst_n),
        .csr_write       (csr_write),
        .csr_read        (csr_read),
        .csr_address     (csr_address),
        .csr_writedata   (csr_writedata),
        .csr_readdata    (csr_readdata),
        .csr_waitrequest (csr_waitrequest),
        .init_done       (init_done),
        .cfg_error       (cfg_error),
        .link_up         (link_up),
        .link_speed      (link_speed)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push(input bit wr, input logic [5:0] a, input logic [31:0] wd, input logic [15:0] rd, input int ws, input int lat);
        acc_t e;
        e.wr = wr;
        e.addr = a;
        e.wdata = wd;
        e.rd = rd;
        e.ws = ws;
        e.lat = lat;
        sb.push_back(e);
    endtask
    // Waits for the next access, checks it against the queue head and holds it for e.ws stall cycles
    task automatic serve();
        acc_t e;
        int n;
        e = sb.pop_front();
        n = 0;
        while (!(csr_read || csr_write) && n < 400) begin
            @(negedge clk_50);
            n++;
        end
        if (!(csr_read || csr_write)) begin
            check("strobe_timeout", 32'd0, 32'd1);
            return;
        end
        if (e.lat >= 0) check("first_latency", 32'(n), 32'(e.lat));
        csr_readdata = {16'hDEAD, e.rd};
        csr_waitrequest = e.ws > 0;
        for (int k = 0; k <= e.ws; k++) begin
            if (k > 0) @(negedge clk_50);
            check("strobe_write", {31'b0, csr_write}, {31'b0, e.wr});
            check("strobe_read", {31'b0, csr_read}, {31'b0, !e.wr});
            check("address", {26'b0, csr_address}, {26'b0, e.addr});
            if (e.wr) check("writedata", csr_writedata, e.wdata);
            if (k == e.ws) csr_waitrequest = 1'b0;
        end
        @(negedge clk_50);
        check("strobe_released", {30'b0, csr_read, csr_write}, 32'd0);
        csr_waitrequest = 1'b1;
    endtask
    task automatic check_outputs(input string tag, input logic d, input logic e, input logic l, input logic [1:0] s);
        check({tag, "_init_done"}, {31'b0, init_done}, {31'b0, d});
        check({tag, "_cfg_error"}, {31'b0, cfg_error}, {31'b0, e});
        check({tag, "_link_up"}, {31'b0, link_up}, {31'b0, l});
        check({tag, "_link_speed"}, {30'b0, link_speed}, {30'b0, s});
    endtask
    initial begin
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_strobes", {30'b0, csr_read, csr_write}, 32'd0);
        check("rst_address", {26'b0, csr_address}, 32'd0);
        check("rst_writedata", csr_writedata, 32'd0);
        check_outputs("rst", 1'b0, 1'b0, 1'b0, 2'b00);
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        push(1, 6'h21, 32'h0013_0000, 16'h0, 0, 11);
        push(1, 6'h00, 32'h0000_9140, 16'h0, 0, -1);
        push(0, 6'h00, 32'h0, 16'h9140, 0, -1);
        push(0, 6'h00, 32'h0, 16'h9140, 0, -1);
        push(0, 6'h00, 32'h0, 16'h1140, 0, -1);
        repeat (4) serve();
        check("pre_init_done", {31'b0, init_done}, 32'd0);
        serve();
        @(negedge clk_50);
        check_outputs("init", 1'b1, 1'b0, 1'b0, 2'b00);
        push(0, 6'h01, 32'h0, 16'h796D, 0, -1);
        push(0, 6'h11, 32'h0, 16'hAC00, 0, -1);
        repeat (2) serve();
        @(negedge clk_50);
        check_outputs("poll1", 1'b1, 1'b0, 1'b1, 2'b10);
        push(0, 6'h01, 32'h0, 16'h7969, 0, -1);
        push(0, 6'h11, 32'h0, 16'h4C00, 0, -1);
        repeat (2) serve();
        @(negedge clk_50);
        check_outputs("poll2", 1'b1, 1'b0, 1'b0, 2'b01);
        n = 0;
        while (!csr_read && n < 400) begin
            @(negedge clk_50);
            n++;
        end
        check("held_read", {31'b0, csr_read}, 32'd1);
        check("held_address", {26'b0, csr_address}, 32'h01);
        repeat (2) @(negedge clk_50);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_strobes", {30'b0, csr_read, csr_write}, 32'd0);
        check_outputs("midrst", 1'b0, 1'b0, 1'b0, 2'b00);
        @(negedge clk_50);
        rst_n = 1'b1;
        push(1, 6'h21, 32'h0013_0000, 16'h0, 5, 11);
        push(1, 6'h00, 32'h0000_9140, 16'h0, 5, -1);
        repeat (4) push(0, 6'h00, 32'h0, 16'h9140, 5, -1);
        repeat (6) serve();
        @(negedge clk_50);
        check_outputs("timeout", 1'b0, 1'b1, 1'b0, 2'b00);
        push(0, 6'h01, 32'h0, 16'h796D, 5, -1);
        push(0, 6'h11, 32'h0, 16'h8400, 5, -1);
        repeat (2) serve();
        @(negedge clk_50);
        check_outputs("poll_after_err", 1'b0, 1'b1, 1'b1, 2'b10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end, expected end before 1ms");
        $fatal(1, "watchdog");
    end
endmodule
